// File: rtl/window_pkg.sv
// Constants shared by the 3x3 window generator and the downstream edge-detect stages.
// Slot k of the packed grid sits at bits [k*PIX_W +: PIX_W], with k = row*3 + col.
package window_pkg;

    localparam int PIX_W_DEF  = 10;
    localparam int GRID_W_DEF = 9 * PIX_W_DEF;

    // Row 0 is the current line and column 0 is the newest pixel.
    localparam int SLOT_R0C0 = 0;
    localparam int SLOT_R0C1 = 1;
    localparam int SLOT_R0C2 = 2;
    localparam int SLOT_R1C0 = 3;
    localparam int SLOT_R1C1 = 4;
    localparam int SLOT_R1C2 = 5;
    localparam int SLOT_R2C0 = 6;
    localparam int SLOT_R2C1 = 7;
    localparam int SLOT_R2C2 = 8;

    function automatic int slot_idx(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line delay: each enabled cycle the word written IMG_WIDTH enables ago appears on oData.
// This is a circular RAM with a single pointer; the read is asynchronous so the tap is the same cycle.
module line_buffer #(
    parameter int IMG_WIDTH = 640,
    parameter int PIX_W     = 10
) (
    input  logic             clock,
    input  logic             iReset_n,
    input  logic             iEn,
    input  logic [PIX_W-1:0] iData,
    output logic [PIX_W-1:0] oData
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [PIX_W-1:0] r_mem [IMG_WIDTH];
    logic [AW-1:0]    r_ptr;

    assign oData = r_mem[r_ptr];

    // The RAM has no reset. Stale words are masked downstream by the row gating.
    always_ff @(posedge clock) begin
        if (iEn) r_mem[r_ptr] <= iData;
    end

    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n)
            r_ptr <= '0;
        else if (iEn)
            r_ptr <= (r_ptr == AW'(IMG_WIDTH - 1)) ? '0 : r_ptr + 1'b1;
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator. It takes raster-order pixels and produces a packed window with a valid strobe.
// Optional: define WINDOW_GEN_POS_OUT_EN to add the oX/oY window-centre coordinate outputs.
module window_3x3_gen
    import window_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic                          clock,
    input  logic                          iReset_n,
    input  logic                          iSOF,
    input  logic                          iValid,
    input  logic [PIX_W-1:0]              iPixel,
    output logic [9*PIX_W-1:0]            oGrid,
    output logic                          oValid
`ifdef WINDOW_GEN_POS_OUT_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  oX,
    output logic [$clog2(IMG_HEIGHT)-1:0] oY
`endif
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0] r_col, w_col;
    logic [YW-1:0] r_row, w_row;
    logic          w_win;
    logic          r_valid;
    logic [PIX_W-1:0] w_lb0, w_lb1;
    logic [2:0][PIX_W-1:0]      w_new;
    logic [2:0][2:0][PIX_W-1:0] r_taps;   // [row][col], col 0 = newest

    // A start-of-frame pixel is (0,0), whatever the counters hold.
    assign w_col = iSOF ? '0 : r_col;
    assign w_row = iSOF ? '0 : r_row;
    assign w_win = (w_row >= YW'(2)) && (w_col >= XW'(2));

    line_buffer #(.IMG_WIDTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
        .clock(clock), .iReset_n(iReset_n), .iEn(iValid), .iData(iPixel), .oData(w_lb0)
    );

    line_buffer #(.IMG_WIDTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clock(clock), .iReset_n(iReset_n), .iEn(iValid), .iData(w_lb0), .oData(w_lb1)
    );

    assign w_new[0] = iPixel;
    assign w_new[1] = w_lb0;
    assign w_new[2] = w_lb1;

    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (iValid) begin
            if (w_col == XW'(IMG_WIDTH - 1)) begin
                r_col <= '0;
                r_row <= (w_row == YW'(IMG_HEIGHT - 1)) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_taps  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= iValid && w_win;
            if (iValid) begin
                for (int r = 0; r < 3; r++) begin
                    r_taps[r][2] <= r_taps[r][1];
                    r_taps[r][1] <= r_taps[r][0];
                    r_taps[r][0] <= w_new[r];
                end
            end
        end
    end

    // The tap registers are the registered output grid. They hold while iValid is low.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign oGrid[slot_idx(r, c)*PIX_W +: PIX_W] = r_taps[r][c];
        end
    end

    assign oValid = r_valid;

`ifdef WINDOW_GEN_POS_OUT_EN
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (iValid && w_win) begin
            r_x <= w_col - 1'b1;
            r_y <= w_row - 1'b1;
        end
    end

    assign oX = r_x;
    assign oY = r_y;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on an 8x6 image. A frame-array reference model builds each expected window.
module tb_window_3x3_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 10;
    localparam int GW = 9 * PW;

    logic          clock = 1'b0;
    logic          iReset_n = 1'b0;
    logic          iSOF = 1'b0;
    logic          iValid = 1'b0;
    logic [PW-1:0] iPixel = '0;
    logic [GW-1:0] oGrid;
    logic          oValid;
`ifdef WINDOW_GEN_POS_OUT_EN
    logic [2:0]    oX;
    logic [2:0]    oY;
`endif

    always #5 clock = ~clock;

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clock(clock), .iReset_n(iReset_n), .iSOF(iSOF), .iValid(iValid),
        .iPixel(iPixel), .oGrid(oGrid), .oValid(oValid)
`ifdef WINDOW_GEN_POS_OUT_EN
        , .oX(oX), .oY(oY)
`endif
    );

    typedef struct packed {
        logic [GW-1:0] grid;
        logic [2:0]    x;
        logic [2:0]    y;
        logic [31:0]   cyc;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_pulse = 0;
    int            cyc = 0;
    bit            prev_v = 1'b0;
    logic [GW-1:0] first_grid;
    logic [2:0]    first_x, first_y, last_x, last_y;
    logic [PW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] slot(input logic [GW-1:0] g, input int k);
        return g[k*PW +: PW];
    endfunction

    // Drive one cycle. The model stores the frame as an image and reads each window straight out of it.
    task automatic send(input bit v, input bit sof, input logic [PW-1:0] pix);
        exp_t e;
        @(posedge clock);
        #1;
        iValid = v;
        iSOF   = sof;
        iPixel = pix;
        if (v) begin
            if (sof) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = pix;
            if (mr >= 2 && mc >= 2) begin
                e.grid = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.grid[(r*3+c)*PW +: PW] = img[mr-r][mc-c];
                e.x   = 3'(mc - 1);
                e.y   = 3'(mr - 1);
                e.cyc = 32'(cyc + 1);
                q.push_back(e);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
    endtask

    task automatic idle(input bit sof);
        send(1'b0, sof, 10'($urandom_range(0, 1023)));
    endtask

    // mode: 0 = row*16+col, 1 = random values; vmode: 0 continuous, 1 alternate, 2 random gaps.
    task automatic frame(input int mode, input int vmode, input int rows, input int last_cols);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < ((r == rows - 1) ? last_cols : W); c++) begin
                if (vmode == 1 && !(r == 0 && c == 0)) idle(1'b0);
                if (vmode == 2 && $urandom_range(0, 2) == 0)
                    repeat ($urandom_range(1, 3)) idle(1'($urandom_range(0, 1)));
                send(1'b1, r == 0 && c == 0,
                     (mode == 0) ? 10'(r * 16 + c) : 10'($urandom_range(0, 1023)));
            end
        end
        idle(1'b0);
    endtask

    task automatic drain(input string name, input int exp_pulses);
        repeat (4) @(posedge clock);
        chk({name, "_pulses"}, GW'(n_pulse), GW'(exp_pulses));
        chk({name, "_drained"}, GW'(q.size()), GW'(0));
    endtask

    task automatic chk_first(input string name);
        chk({name, "_s0"}, GW'(slot(first_grid, 0)), GW'(34));
        chk({name, "_s2"}, GW'(slot(first_grid, 2)), GW'(32));
        chk({name, "_s6"}, GW'(slot(first_grid, 6)), GW'(2));
        chk({name, "_s8"}, GW'(slot(first_grid, 8)), GW'(0));
        chk({name, "_s4"}, GW'(slot(first_grid, 4)), GW'(17));
    endtask

    // Monitor: pops one expected window per oValid pulse and checks its arrival cycle.
    always @(negedge clock) begin
        if (!iReset_n) begin
            prev_v = 1'b0;
        end else begin
            if (!prev_v) begin
                n_cmp++;
                if (oValid !== 1'b0) begin
                    n_err++;
                    $display("FAIL valid_after_idle: got %b expected 0", oValid);
                end
            end
            if (oValid === 1'b1) begin
                n_pulse++;
                if (n_pulse == 1) begin
                    first_grid = oGrid;
`ifdef WINDOW_GEN_POS_OUT_EN
                    first_x = oX;
                    first_y = oY;
`endif
                end
`ifdef WINDOW_GEN_POS_OUT_EN
                last_x = oX;
                last_y = oY;
`endif
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_window: got %h expected none", oGrid);
                end else begin
                    mon_e = q.pop_front();
                    chk("grid", oGrid, mon_e.grid);
                    chk("latency", GW'(cyc), GW'(mon_e.cyc));
`ifdef WINDOW_GEN_POS_OUT_EN
                    chk("pos_x", GW'(oX), GW'(mon_e.x));
                    chk("pos_y", GW'(oY), GW'(mon_e.y));
`endif
                end
            end
            prev_v = iValid;
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", GW'(oValid), GW'(0));
        chk("rst_grid", oGrid, '0);
`ifdef WINDOW_GEN_POS_OUT_EN
        chk("rst_x", GW'(oX), GW'(0));
        chk("rst_y", GW'(oY), GW'(0));
`endif
        iReset_n = 1'b1;

        // Continuous full frame
        n_pulse = 0;
        frame(0, 0, H, W);
        drain("full", 24);
        chk_first("first");
`ifdef WINDOW_GEN_POS_OUT_EN
        chk("first_x", GW'(first_x), GW'(1));
        chk("first_y", GW'(first_y), GW'(1));
        chk("last_x", GW'(last_x), GW'(6));
        chk("last_y", GW'(last_y), GW'(4));
`endif

        // Alternating iValid
        n_pulse = 0;
        frame(0, 1, H, W);
        drain("alt", 24);
        chk_first("alt_first");

        // Random values, random gaps, stray iSOF while idle
        n_pulse = 0;
        frame(1, 2, H, W);
        drain("gaps", 24);

        // Mid-frame restart at (3,5)
        n_pulse = 0;
        frame(1, 0, 4, 5);
        frame(1, 0, H, W);
        drain("midsof", 33);

        // Async reset during line 3, while a valid window is on the outputs
        frame(0, 0, 4, 4);
        #3;
        iValid   = 1'b0;
        iSOF     = 1'b0;
        iReset_n = 1'b0;
        #1;
        chk("arst_valid", GW'(oValid), GW'(0));
        chk("arst_grid", oGrid, '0);
        q.delete();
        mr = 0;
        mc = 0;
        repeat (2) @(posedge clock);
        #1;
        iReset_n = 1'b1;
        n_pulse = 0;
        frame(0, 0, H, W);
        drain("post_rst", 24);
        chk_first("post_rst_first");

        // Two back-to-back random frames
        n_pulse = 0;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    send(1'b1, r == 0 && c == 0, 10'($urandom_range(0, 1023)));
        idle(1'b0);
        drain("b2b", 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator. Sits directly upstream of the vertical/horizontal 3x3 edge-detect stages.
- Accepts one 10-bit grey pixel per valid cycle in raster order and buffers the two previous lines.
- Emits the packed 90-bit 3x3 window those stages consume on their grid input, with a valid strobe.

Parameters:
- IMG_WIDTH, 640, active pixels per line (min 3).
- IMG_HEIGHT, 480, active lines per frame (min 3).
- PIX_W, 10, bits per pixel; grid width is 9*PIX_W.

Ports:
- clock  in  1  single system clock; all logic rising-edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iSOF  in  1  start of frame; qualified by iValid; marks the pixel at (0,0).
- iValid  in  1  iPixel valid this cycle.
- iPixel  in  PIX_W  input pixel intensity.
- oGrid  out  9*PIX_W  packed window.
- oValid  out  1  oGrid holds a complete window this cycle.

Behaviour:
- Window packing:
  - Slot k = oGrid[k*PIX_W +: PIX_W], with k = r*3 + c.
  - r=0 is the current line, r=2 is two lines back.
  - c=0 is the newest pixel, c=2 is two pixels older.
  - So slots 0,3,6 form the newest (right) column and slots 2,5,8 the oldest (left) column.
- Counters:
  - col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on iValid.
  - col wraps to 0 and row increments at end of line.
  - row wraps to 0 after the last line.
- Line buffers:
  - Two delay lines of IMG_WIDTH words each; written/shifted only on iValid.
  - Line buffer 0 output is pixel (row-1, col); line buffer 1 output is pixel (row-2, col).
  - Tap registers (3 rows x 3 columns) shift only on iValid.
- Latency: oGrid/oValid are registered; they update 1 clock after the accepted pixel at (row, col).
- oValid = 1 for exactly one cycle when the accepted pixel has row>=2 and col>=2; otherwise 0.
  - No windows are produced for the first two lines or the first two columns of each line (no padding).
- iValid low:
  - Nothing shifts; counters hold.
  - oValid = 0; oGrid holds its last value.
- iSOF with iValid:
  - Forces col=0, row=0 for that pixel, even mid-frame.
  - Line buffer contents are not cleared, but oValid stays low until row>=2 of the new frame, so stale data never appears in a valid window.
- iSOF without iValid: ignored.
- Reset (asynchronous, any time, including mid-line):
  - oValid=0, oGrid=0, col=0, row=0, taps=0.
  - Line buffer RAM contents are undefined and are never exposed, by the rule above.
- Arithmetic: pure data movement, no arithmetic on pixel values; counters sized $clog2 of the respective dimension.
- Back-to-back frames with no gap are supported.

Optional Feature:
- Macro WINDOW_GEN_POS_OUT_EN.
- Defined:
  - Adds outputs oX (clog2 IMG_WIDTH bits) and oY (clog2 IMG_HEIGHT bits).
  - They carry the image coordinate of the window centre (col-1, row-1), registered alongside oGrid.
  - Reset value 0; they hold when oValid=0.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package window_pkg:
  - PIX_W default.
  - GRID_W = 9*PIX_W.
  - Slot index constants: SLOT_R0C0 .. SLOT_R2C2.
  - Edge-detect stages use the same constants.
- Sub-module line_buffer:
  - Parameterised IMG_WIDTH x PIX_W delay line, RAM-inferable, with enable.
  - Instantiated twice.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = row*16+col):
- Full frame with continuous iValid and iSOF on the first pixel -> exactly 24 oValid pulses; first pulse 1 cycle after pixel (2,2) accepted.
  - First window: slot0=34, slot2=32, slot6=2, slot8=0, slot4=17.
- Same frame with iValid deasserted on every other cycle -> identical oGrid sequence; oValid never high in a cycle following iValid=0.
- Mid-frame iSOF at pixel (3,5) -> row/col restart; no oValid until the new row 2, col 2.
  - First new window slot0 = value of the pixel sent at new (2,2).
- Async reset asserted mid-line 3 for 2 cycles -> oValid and oGrid go to 0 immediately.
  - After release plus a new frame, the first window matches the first scenario.
- Two back-to-back frames with no gap -> 48 oValid pulses total; second frame's first window contains no first-frame values.
- With WINDOW_GEN_POS_OUT_EN defined -> the first window reports oX=1, oY=1; the last window of the frame reports oX=6, oY=4.
